// File: rtl/detect_sequence_param_shift_reg.sv
// ---------------------------------------------------------------------------
// detect_sequence_param_shift_reg
//
// Purpose:
//   This module detects a configurable serial bit pattern. Incoming bits are
//   shifted into a MAX_LEN-bit history register. A one-cycle pulse is raised
//   on `detected` when the low `len` bits of the history equal the low `len`
//   bits of the registered pattern.
//
//   Overlapping or non-overlapping matching is selectable.
//
//   A fill counter gates every match. Zeros left in the history by reset or
//   by a configuration load therefore never count as received data.
//
// Optional feature:
//   Define SEQ_DET_MATCH_COUNT_EN to build a saturating match counter.
//   When the macro is undefined, match_count is tied to zero and no counter
//   logic exists.
//
// Parameters:
//   MAX_LEN  maximum pattern length in bits (2..32)
//   CNT_W    width of match_count
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   cfg_load       capture cfg_pattern/cfg_len/cfg_overlap this cycle
//   cfg_pattern    target pattern; bit len-1 is received first, bit 0 last
//   cfg_len        active pattern length; values above MAX_LEN are clamped
//   cfg_overlap    1 = overlapping matches, 0 = non-overlapping matches
//   new_bit_valid  qualifies new_bit
//   new_bit        serial data bit
//   detected       registered one-cycle match pulse
//   match_count    saturating count of matches (0 when the counter is absent)
// ---------------------------------------------------------------------------
module detect_sequence_param_shift_reg #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               new_bit_valid,
  input  logic               new_bit,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_TWO = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] history;
  logic [LEN_W-1:0]   fill;

  logic               accept;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] len_mask;
  logic               match;

  // Post-shift history, saturating fill count, length mask and match decision.
  always_comb begin
    accept    = new_bit_valid & ~cfg_load;
    hist_next = {history[MAX_LEN-2:0], new_bit};
    len_mask  = {MAX_LEN{1'b0}};

    if (fill < len_q) begin
      fill_next = fill + LEN_ONE;
    end else begin
      fill_next = fill;
    end

    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end

    // A length of 0 or 1 disables detection altogether.
    if (accept && (len_q >= LEN_TWO) && (fill_next >= len_q)) begin
      match = ((hist_next & len_mask) == (pattern_q & len_mask));
    end else begin
      match = 1'b0;
    end
  end

  // Configuration capture, history shift, fill tracking and the match pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= {MAX_LEN{1'b0}};
      len_q     <= {LEN_W{1'b0}};
      overlap_q <= 1'b0;
      history   <= {MAX_LEN{1'b0}};
      fill      <= {LEN_W{1'b0}};
      detected  <= 1'b0;
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      len_q     <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      overlap_q <= cfg_overlap;
      history   <= {MAX_LEN{1'b0}};
      fill      <= {LEN_W{1'b0}};
      detected  <= 1'b0;
    end else if (accept) begin
      history  <= hist_next;
      // In non-overlap mode a match consumes its bits, so the next match
      // needs len fresh bits.
      fill     <= (match && !overlap_q) ? {LEN_W{1'b0}} : fill_next;
      detected <= match;
    end else begin
      detected <= 1'b0;
    end
  end

`ifdef SEQ_DET_MATCH_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;

  // Saturating match counter, cleared by reset or by a configuration load.
  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      count_q <= {CNT_W{1'b0}};
    end else if (match && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_ONE;
    end else begin
      count_q <= count_q;
    end
  end

  assign match_count = count_q;
`else
  assign match_count = {CNT_W{1'b0}};
`endif

endmodule
